// File: rtl/pc_sequencer_pkg.sv
// Shared configuration and types for the jacaranda control-flow unit.
// Holds the core-wide sizing constants, the return-stack entry and a width helper.
package pc_sequencer_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  localparam int unsigned PC_W        = 8;
  localparam int unsigned N_IRQ       = 4;
  localparam int unsigned STACK_DEPTH = 4;
  localparam int unsigned VEC_STRIDE  = 4;
  localparam int unsigned RESET_PC    = 0;

  // Priority value meaning "no ISR running": lower than every real source.
  localparam int unsigned NO_PRIO   = N_IRQ;
  localparam int unsigned PRIO_W    = clog2(N_IRQ + 1);
  localparam int unsigned IDX_W     = clog2(N_IRQ);
  localparam int unsigned DEPTH_W   = clog2(STACK_DEPTH + 1);
  localparam int unsigned STK_IDX_W = clog2(STACK_DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              flag;
    logic [PRIO_W-1:0] prio;
  } stack_entry_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control bundle between decoder/controller (master) and the PC sequencer (slave).
interface pc_sequencer_if;
  import pc_sequencer_pkg::*;

  logic               stall;
  logic               jmp_en;
  logic               je_en;
  logic               reti_en;
  logic               flag_w_en;
  logic               flag_in;
  logic [PC_W-1:0]    target;
  logic [N_IRQ-1:0]   irq_req;
  logic [N_IRQ-1:0]   irq_mask;
  logic [PC_W-1:0]    irq_vec_base;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    ret_addr;
  logic               flag;
  logic [N_IRQ-1:0]   irq_ack;
  logic               in_isr;
  logic [DEPTH_W-1:0] depth;
  logic               err_underflow;

  modport master (
    output stall, jmp_en, je_en, reti_en, flag_w_en, flag_in, target,
           irq_req, irq_mask, irq_vec_base,
    input  pc, ret_addr, flag, irq_ack, in_isr, depth, err_underflow
  );

  modport slave (
    input  stall, jmp_en, je_en, reti_en, flag_w_en, flag_in, target,
           irq_req, irq_mask, irq_vec_base,
    output pc, ret_addr, flag, irq_ack, in_isr, depth, err_underflow
  );

endinterface

// File: rtl/pc_sequencer_irq_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module irq_prio_enc #(
  parameter int unsigned N = pc_sequencer_pkg::N_IRQ,
  parameter int unsigned W = pc_sequencer_pkg::IDX_W
) (
  input  logic [N-1:0] i_req,
  output logic         o_valid_c,
  output logic [W-1:0] o_idx_c
);

  always_comb begin
    o_valid_c = 1'b0;
    o_idx_c   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid_c = 1'b1;
        o_idx_c   = W'(i);
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC, flag, jump and nested vectored-interrupt sequencing for the jacaranda core.
// Interrupt context lives in a small register return stack indexed by depth.
module pc_sequencer
  import pc_sequencer_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst,
  pc_sequencer_if.slave  io_seq
);

  logic [PC_W-1:0]      r_pc;
  logic                 r_flag;
  logic [DEPTH_W-1:0]   r_depth;
  logic                 r_in_isr;
  logic [N_IRQ-1:0]     r_irq_ack;
  logic                 r_err_underflow;
  stack_entry_t         r_stack [STACK_DEPTH];

  logic [PC_W-1:0]      w_nxt;
  logic                 w_nflag;
  logic [STK_IDX_W-1:0] w_top_sel;
  logic [STK_IDX_W-1:0] w_push_sel;
  stack_entry_t         w_top;
  logic [PRIO_W-1:0]    w_cur_prio;
  logic                 w_cand_valid;
  logic [IDX_W-1:0]     w_cand_idx;
  logic [PC_W-1:0]      w_vec_off;
  logic [PC_W-1:0]      w_vec;
  logic                 w_take;

  assign w_nxt   = (io_seq.jmp_en || (io_seq.je_en && r_flag)) ? io_seq.target
                                                               : PC_W'(r_pc + PC_W'(1));
  assign w_nflag = io_seq.je_en ? 1'b0 : (io_seq.flag_w_en ? io_seq.flag_in : r_flag);

  assign w_top_sel  = STK_IDX_W'(r_depth - DEPTH_W'(1));
  assign w_push_sel = STK_IDX_W'(r_depth);
  assign w_top      = r_stack[w_top_sel];
  assign w_cur_prio = (r_depth != '0) ? w_top.prio : PRIO_W'(NO_PRIO);

  irq_prio_enc #(.N(N_IRQ), .W(IDX_W)) u_prio_enc (
    .i_req     (io_seq.irq_req & io_seq.irq_mask),
    .o_valid_c (w_cand_valid),
    .o_idx_c   (w_cand_idx)
  );

  assign w_vec_off = PC_W'(w_cand_idx) * PC_W'(VEC_STRIDE);
  assign w_vec     = PC_W'(io_seq.irq_vec_base + w_vec_off);

  // Only strictly higher priority than the running ISR may preempt, and only with stack room.
  assign w_take = !io_seq.stall && !io_seq.reti_en && w_cand_valid
               && (PRIO_W'(w_cand_idx) < w_cur_prio)
               && (r_depth < DEPTH_W'(STACK_DEPTH));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc            <= PC_W'(RESET_PC);
      r_flag          <= 1'b0;
      r_depth         <= '0;
      r_in_isr        <= 1'b0;
      r_irq_ack       <= '0;
      r_err_underflow <= 1'b0;
    end else begin
      r_irq_ack <= '0;
      if (!io_seq.stall) begin
        if (io_seq.reti_en && (r_depth != '0)) begin
          r_pc     <= w_top.pc;
          r_flag   <= w_top.flag;
          r_depth  <= r_depth - DEPTH_W'(1);
          r_in_isr <= (r_depth != DEPTH_W'(1));
        end else if (w_take) begin
          r_pc      <= w_vec;
          r_flag    <= 1'b0;
          r_depth   <= r_depth + DEPTH_W'(1);
          r_in_isr  <= 1'b1;
          r_irq_ack <= N_IRQ'(1) << w_cand_idx;
        end else if (io_seq.reti_en) begin
          // Return with nothing to return to: treat as a plain jump and flag it.
          r_pc            <= io_seq.target;
          r_flag          <= w_nflag;
          r_err_underflow <= 1'b1;
        end else begin
          r_pc   <= w_nxt;
          r_flag <= w_nflag;
        end
      end
    end
  end

  // Stack contents need no reset; validity is tracked by depth.
  always_ff @(posedge i_clk) begin
    if (w_take) begin
      r_stack[w_push_sel] <= '{pc: w_nxt, flag: w_nflag, prio: PRIO_W'(w_cand_idx)};
    end
  end

  assign io_seq.pc            = r_pc;
  assign io_seq.ret_addr      = w_nxt;
  assign io_seq.flag          = r_flag;
  assign io_seq.irq_ack       = r_irq_ack;
  assign io_seq.in_isr        = r_in_isr;
  assign io_seq.depth         = r_depth;
  assign io_seq.err_underflow = r_err_underflow;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer: jumps, vectored nested IRQs, stack limits, underflow, reset.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  logic e_err;

  typedef struct {
    string      tag;
    logic [7:0] pc;
    logic       flag;
    logic [2:0] depth;
    logic [3:0] ack;
    logic       err;
  } exp_t;

  exp_t exp_q[$];

  pc_sequencer_if u_if ();

  pc_sequencer u_dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_seq (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    u_if.stall     = 1'b0;
    u_if.jmp_en    = 1'b0;
    u_if.je_en     = 1'b0;
    u_if.reti_en   = 1'b0;
    u_if.flag_w_en = 1'b0;
    u_if.flag_in   = 1'b0;
    u_if.target    = 8'h00;
    u_if.irq_req   = 4'b0000;
    u_if.irq_mask  = 4'b1111;
  endtask

  task automatic check_front();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, ".pc"},     32'(u_if.pc),            32'(e.pc));
      chk({e.tag, ".flag"},   32'(u_if.flag),          32'(e.flag));
      chk({e.tag, ".depth"},  32'(u_if.depth),         32'(e.depth));
      chk({e.tag, ".in_isr"}, 32'(u_if.in_isr),        32'(e.depth != 3'd0));
      chk({e.tag, ".ack"},    32'(u_if.irq_ack),       32'(e.ack));
      chk({e.tag, ".err"},    32'(u_if.err_underflow), 32'(e.err));
    end
  endtask

  // Inputs are already driven; record the expected post-edge state, clock once, compare.
  task automatic step(input string tag, input logic [7:0] pc, input logic flag,
                      input logic [2:0] depth, input logic [3:0] ack);
    exp_t e;
    e.tag = tag; e.pc = pc; e.flag = flag; e.depth = depth; e.ack = ack; e.err = e_err;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_front();
    clear_inputs();
  endtask

  task automatic chk_ret(input string tag, input logic [7:0] exp);
    #1;
    chk(tag, 32'(u_if.ret_addr), 32'(exp));
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    e_err    = 1'b0;
    rst      = 1'b0;
    u_if.irq_vec_base = 8'h40;
    clear_inputs();

    #2 rst = 1'b1;
    #1;
    chk("reset.pc",     32'(u_if.pc), 32'h00);
    chk("reset.flag",   32'(u_if.flag), 32'd0);
    chk("reset.depth",  32'(u_if.depth), 32'd0);
    chk("reset.in_isr", 32'(u_if.in_isr), 32'd0);
    chk("reset.ack",    32'(u_if.irq_ack), 32'd0);
    chk("reset.err",    32'(u_if.err_underflow), 32'd0);
    chk("reset.ret_addr", 32'(u_if.ret_addr), 32'h01);
    @(posedge clk);
    #1 rst = 1'b0;

    // Jumps and conditional jumps
    u_if.jmp_en = 1'b1; u_if.target = 8'h10; u_if.flag_w_en = 1'b1; u_if.flag_in = 1'b1;
    step("jmp_setflag", 8'h10, 1'b1, 3'd0, 4'b0000);
    u_if.je_en = 1'b1; u_if.target = 8'h80;
    chk_ret("je_taken.ret_addr", 8'h80);
    step("je_taken", 8'h80, 1'b0, 3'd0, 4'b0000);
    u_if.jmp_en = 1'b1; u_if.target = 8'h10;
    step("jmp_back", 8'h10, 1'b0, 3'd0, 4'b0000);
    u_if.je_en = 1'b1; u_if.target = 8'h80;
    chk_ret("je_not_taken.ret_addr", 8'h11);
    step("je_not_taken", 8'h11, 1'b0, 3'd0, 4'b0000);

    // Single IRQ entry and return
    u_if.jmp_en = 1'b1; u_if.target = 8'h05; u_if.flag_w_en = 1'b1; u_if.flag_in = 1'b1;
    step("jmp_05", 8'h05, 1'b1, 3'd0, 4'b0000);
    u_if.irq_req = 4'b0100;
    chk_ret("irq2.ret_addr", 8'h06);
    step("irq2_take", 8'h48, 1'b0, 3'd1, 4'b0100);
    step("isr2_run", 8'h49, 1'b0, 3'd1, 4'b0000);
    u_if.reti_en = 1'b1;
    step("reti_irq2", 8'h06, 1'b1, 3'd0, 4'b0000);

    // Nesting and priority blocking
    u_if.irq_req = 4'b0100;
    step("nest_irq2", 8'h48, 1'b0, 3'd1, 4'b0100);
    u_if.irq_req = 4'b0001;
    step("nest_irq0", 8'h40, 1'b0, 3'd2, 4'b0001);
    u_if.irq_req = 4'b1000;
    step("irq3_blk_a", 8'h41, 1'b0, 3'd2, 4'b0000);
    u_if.irq_req = 4'b1000; u_if.reti_en = 1'b1;
    step("reti_to2", 8'h49, 1'b0, 3'd1, 4'b0000);
    u_if.irq_req = 4'b1000;
    step("irq3_blk_b", 8'h4A, 1'b0, 3'd1, 4'b0000);
    u_if.irq_req = 4'b1000; u_if.reti_en = 1'b1;
    step("reti_plus_irq", 8'h07, 1'b1, 3'd0, 4'b0000);
    u_if.irq_req = 4'b1000;
    step("irq3_tail", 8'h4C, 1'b0, 3'd1, 4'b1000);
    step("isr3_run", 8'h4D, 1'b0, 3'd1, 4'b0000);
    u_if.reti_en = 1'b1;
    step("reti_irq3", 8'h08, 1'b1, 3'd0, 4'b0000);

    // Fill the return stack, then unwind
    u_if.irq_req = 4'b1000;
    step("fill_3", 8'h4C, 1'b0, 3'd1, 4'b1000);
    u_if.irq_req = 4'b0100;
    step("fill_2", 8'h48, 1'b0, 3'd2, 4'b0100);
    u_if.irq_req = 4'b0010;
    step("fill_1", 8'h44, 1'b0, 3'd3, 4'b0010);
    u_if.irq_req = 4'b0001;
    step("fill_0", 8'h40, 1'b0, 3'd4, 4'b0001);
    u_if.irq_req = 4'b0001;
    step("full_blk_a", 8'h41, 1'b0, 3'd4, 4'b0000);
    u_if.irq_req = 4'b0001; u_if.flag_w_en = 1'b1; u_if.flag_in = 1'b1;
    step("full_blk_b", 8'h42, 1'b1, 3'd4, 4'b0000);
    u_if.reti_en = 1'b1;
    step("unwind_3", 8'h45, 1'b0, 3'd3, 4'b0000);
    u_if.reti_en = 1'b1;
    step("unwind_2", 8'h49, 1'b0, 3'd2, 4'b0000);
    u_if.reti_en = 1'b1;
    step("unwind_1", 8'h4D, 1'b0, 3'd1, 4'b0000);
    u_if.reti_en = 1'b1;
    step("unwind_0", 8'h09, 1'b1, 3'd0, 4'b0000);

    // Masking
    u_if.irq_req = 4'b0010; u_if.irq_mask = 4'b1101;
    step("masked", 8'h0A, 1'b1, 3'd0, 4'b0000);
    u_if.irq_req = 4'b0010;
    step("unmasked", 8'h44, 1'b0, 3'd1, 4'b0010);
    u_if.reti_en = 1'b1;
    step("reti_irq1", 8'h0B, 1'b1, 3'd0, 4'b0000);

    // Stall holds everything
    u_if.stall = 1'b1; u_if.irq_req = 4'b0001; u_if.jmp_en = 1'b1; u_if.target = 8'h77;
    u_if.flag_w_en = 1'b1; u_if.flag_in = 1'b0;
    step("stall", 8'h0B, 1'b1, 3'd0, 4'b0000);

    // Underflow: reti at depth 0 acts as a jump and sets the sticky error
    u_if.reti_en = 1'b1; u_if.target = 8'h30;
    e_err = 1'b1;
    step("underflow", 8'h30, 1'b1, 3'd0, 4'b0000);
    step("underflow_sticky", 8'h31, 1'b1, 3'd0, 4'b0000);

    // PC wrap
    u_if.jmp_en = 1'b1; u_if.target = 8'hFF;
    step("jmp_ff", 8'hFF, 1'b1, 3'd0, 4'b0000);
    chk_ret("wrap.ret_addr", 8'h00);
    step("wrap", 8'h00, 1'b1, 3'd0, 4'b0000);

    // Async reset in the middle of nested interrupts
    u_if.irq_req = 4'b0100;
    step("pre_rst_irq2", 8'h48, 1'b0, 3'd1, 4'b0100);
    u_if.irq_req = 4'b0001;
    step("pre_rst_irq0", 8'h40, 1'b0, 3'd2, 4'b0001);
    u_if.jmp_en = 1'b1; u_if.target = 8'h23; u_if.flag_w_en = 1'b1; u_if.flag_in = 1'b1;
    step("pre_rst_jmp", 8'h23, 1'b1, 3'd2, 4'b0000);
    #2 rst = 1'b1;
    #1;
    chk("midrst.pc",     32'(u_if.pc), 32'h00);
    chk("midrst.flag",   32'(u_if.flag), 32'd0);
    chk("midrst.depth",  32'(u_if.depth), 32'd0);
    chk("midrst.in_isr", 32'(u_if.in_isr), 32'd0);
    chk("midrst.err",    32'(u_if.err_underflow), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    e_err = 1'b0;
    step("post_rst", 8'h01, 1'b0, 3'd0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
